// File: rtl/lights_sequencer.sv
// Light sequencer: steps an RGB colour code 1..6 on button presses or a dwell timer,
// with a forced-white override. Optional button debouncer under LIGHTS_SEQ_DEBOUNCE_EN.
module lights_sequencer #(
  parameter int DWELL_W      = 16,
  parameter int DWELL_CYCLES = 1000,
  parameter int DEB_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic       auto_en,
  input  logic       white_req,
  output logic [2:0] colour,
  output logic       enable,
  output logic       sel,
  output logic       light_valid
);

  typedef enum logic [1:0] {INIT = 2'd0, WHITE = 2'd1, FETCH = 2'd2, SHOW = 2'd3} state_t;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  // Elaboration-time parameter sanity checks
  if (DEB_CYCLES < 1) begin : g_deb_chk
    $error("DEB_CYCLES must be at least 1");
  end
  if ((DWELL_CYCLES < 2) || (longint'(DWELL_CYCLES) > ((longint'(1) << DWELL_W) - 1))) begin : g_dwell_chk
    $error("DWELL_CYCLES out of range for DWELL_W");
  end

  state_t             state_r, state_s;
  logic [2:0]         colour_r, colour_s;
  logic [DWELL_W-1:0] dwell_r, dwell_s;
  logic               sync1_r, sync2_r, level_s, prev_r, armed_r;
  logic               press_s, expire_s, settled_s;
  logic               sel_r, enable_r, valid_r;

  function automatic logic [2:0] next_colour(input logic [2:0] c);
    if ((c >= 3'd6) || (c == 3'd0)) return 3'd1;
    else return c + 3'd1;
  endfunction

  // {sel, enable, light_valid} for a given state
  function automatic logic [2:0] decode_outputs(input state_t s);
    case (s)
      INIT:    return 3'b000;
      WHITE:   return 3'b001;
      FETCH:   return 3'b110;
      SHOW:    return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= button;
      sync2_r <= sync1_r;
    end
  end

`ifdef LIGHTS_SEQ_DEBOUNCE_EN
  localparam int SETTLE = 2 + DEB_CYCLES;
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  logic [DEB_W-1:0] deb_cnt_r;
  logic             filt_r;

  // Filtered level flips only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt_r <= '0;
      filt_r    <= 1'b0;
    end else if (sync2_r == filt_r) begin
      deb_cnt_r <= '0;
    end else if (deb_cnt_r == DEB_W'(DEB_CYCLES - 1)) begin
      deb_cnt_r <= '0;
      filt_r    <= sync2_r;
    end else begin
      deb_cnt_r <= deb_cnt_r + DEB_W'(1);
    end
  end

  assign level_s = filt_r;
`else
  localparam int SETTLE = 2;
  assign level_s = sync2_r;
`endif

  // The pipeline reads 0 right after reset even with the button held; arming waits
  // until the level can reflect the real button, so a held button needs a release first.
  localparam int SET_W = $clog2(SETTLE + 1);
  logic [SET_W-1:0] settle_r;
  assign settled_s = (settle_r == SET_W'(SETTLE));

  // Press edge detector with post-reset arming
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_r   <= 1'b0;
      armed_r  <= 1'b0;
      settle_r <= '0;
    end else begin
      prev_r   <= level_s;
      armed_r  <= armed_r | (settled_s & ~level_s);
      settle_r <= settled_s ? settle_r : (settle_r + SET_W'(1));
    end
  end

  assign press_s  = level_s & ~prev_r & armed_r;
  assign expire_s = auto_en & (dwell_r == DWELL_LAST);

  // Next-state, colour and dwell counter logic
  always_comb begin
    state_s  = state_r;
    colour_s = colour_r;
    dwell_s  = '0;
    case (state_r)
      INIT: begin
        state_s = WHITE;
      end
      WHITE: begin
        if (!white_req && press_s) state_s = FETCH;
        else state_s = WHITE;
      end
      FETCH: begin
        if (white_req) state_s = WHITE;
        else state_s = SHOW;
      end
      SHOW: begin
        if (white_req) begin
          state_s = WHITE;
        end else if (press_s || expire_s) begin
          state_s  = FETCH;
          colour_s = next_colour(colour_r);
        end else if (auto_en) begin
          dwell_s = dwell_r + DWELL_W'(1);
        end else begin
          dwell_s = dwell_r;
        end
      end
      default: begin
        state_s = INIT;
      end
    endcase
  end

  // State, colour, dwell and registered output decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= INIT;
      colour_r <= 3'd1;
      dwell_r  <= '0;
      sel_r    <= 1'b0;
      enable_r <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      colour_r <= colour_s;
      dwell_r  <= dwell_s;
      {sel_r, enable_r, valid_r} <= decode_outputs(state_s);
    end
  end

  assign colour      = colour_r;
  assign sel         = sel_r;
  assign enable      = enable_r;
  assign light_valid = valid_r;

endmodule

// File: tb/tb_lights_sequencer.sv
// Directed self-checking bench for lights_sequencer (DWELL_CYCLES=4).
module tb_lights_sequencer;

  localparam int DEB = 8;
`ifdef LIGHTS_SEQ_DEBOUNCE_EN
  localparam int PRESS_LAT = 3 + DEB;
`else
  localparam int PRESS_LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst, button, auto_en, white_req;
  logic [2:0] colour;
  logic       enable, sel, light_valid;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  lights_sequencer #(
    .DWELL_W(16), .DWELL_CYCLES(4), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .auto_en(auto_en), .white_req(white_req),
    .colour(colour), .enable(enable), .sel(sel), .light_valid(light_valid)
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Packed as {colour, sel, enable, light_valid}
  task automatic expect_out(input string tag, input logic [2:0] c, input logic s,
                            input logic e, input logic v);
    check_eq(tag, {2'b00, colour, sel, enable, light_valid}, {2'b00, c, s, e, v});
  endtask

  task automatic press_and_show(input string tag, input logic from_white,
                                input logic [2:0] pre_c, input logic [2:0] c);
    button = 1'b1;
    step(PRESS_LAT - 1);
    expect_out({tag, "_pre"}, pre_c, ~from_white, ~from_white, 1'b1);
    step(1);
    expect_out({tag, "_fetch"}, c, 1'b1, 1'b1, 1'b0);
    step(1);
    expect_out({tag, "_show"}, c, 1'b1, 1'b1, 1'b1);
    step(PRESS_LAT - 1);
    button = 1'b0;
    step(PRESS_LAT + 1);
  endtask

  initial begin
    logic [2:0] seq [7];
    logic [2:0] prev_c;
    seq = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2};
    rst = 1'b0; button = 1'b0; auto_en = 1'b0; white_req = 1'b0;

    step(2);
    expect_out("reset", 3'd1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    expect_out("init", 3'd1, 1'b0, 1'b0, 1'b0);
    step(1);
    expect_out("white", 3'd1, 1'b0, 1'b0, 1'b1);
    step(5);
    expect_out("white_idle", 3'd1, 1'b0, 1'b0, 1'b1);

    press_and_show("p0", 1'b1, 3'd1, 3'd1);
    prev_c = 3'd1;
    for (int i = 0; i < 7; i++) begin
      press_and_show($sformatf("p%0d", i + 1), 1'b0, prev_c, seq[i]);
      prev_c = seq[i];
    end

    // Timed advance, then pause mid-dwell and resume
    auto_en = 1'b1;
    step(3);
    expect_out("dwell_hold", 3'd2, 1'b1, 1'b1, 1'b1);
    step(1);
    expect_out("auto_fetch", 3'd3, 1'b1, 1'b1, 1'b0);
    step(1);
    expect_out("auto_show", 3'd3, 1'b1, 1'b1, 1'b1);
    step(2);
    auto_en = 1'b0;
    step(10);
    expect_out("paused", 3'd3, 1'b1, 1'b1, 1'b1);
    auto_en = 1'b1;
    step(1);
    expect_out("resume_pre", 3'd3, 1'b1, 1'b1, 1'b1);
    step(1);
    expect_out("resume_fetch", 3'd4, 1'b1, 1'b1, 1'b0);

    // white_req during FETCH
    white_req = 1'b1;
    auto_en = 1'b0;
    step(1);
    expect_out("white_force", 3'd4, 1'b0, 1'b0, 1'b1);
    white_req = 1'b0;
    step(2);
    expect_out("white_stay", 3'd4, 1'b0, 1'b0, 1'b1);
    press_and_show("rearm", 1'b1, 3'd4, 3'd4);
    press_and_show("to5", 1'b0, 3'd4, 3'd5);
    press_and_show("to6", 1'b0, 3'd5, 3'd6);

    // Press coincident with timer expiry at colour 6
    if (PRESS_LAT <= 4) begin
      auto_en = 1'b1;
      step(4 - PRESS_LAT);
      button = 1'b1;
      step(PRESS_LAT - 1);
    end else begin
      button = 1'b1;
      step(PRESS_LAT - 4);
      auto_en = 1'b1;
      step(3);
    end
    expect_out("coinc_pre", 3'd6, 1'b1, 1'b1, 1'b1);
    step(1);
    expect_out("coinc_fetch", 3'd1, 1'b1, 1'b1, 1'b0);
    auto_en = 1'b0;
    step(1);
    expect_out("coinc_show", 3'd1, 1'b1, 1'b1, 1'b1);
    step(PRESS_LAT);
    button = 1'b0;
    step(PRESS_LAT + 1);
    expect_out("coinc_single", 3'd1, 1'b1, 1'b1, 1'b1);

    // white_req beats a simultaneous press
    button = 1'b1;
    white_req = 1'b1;
    step(1);
    expect_out("white_show", 3'd1, 1'b0, 1'b0, 1'b1);
    step(PRESS_LAT + 1);
    expect_out("white_vs_press", 3'd1, 1'b0, 1'b0, 1'b1);
    white_req = 1'b0;
    button = 1'b0;
    step(PRESS_LAT + 1);
    expect_out("white_no_fetch", 3'd1, 1'b0, 1'b0, 1'b1);

    // Reset mid-SHOW, with the button held through reset release
    press_and_show("s1", 1'b1, 3'd1, 3'd1);
    press_and_show("s2", 1'b0, 3'd1, 3'd2);
    rst = 1'b0;
    #1;
    expect_out("rst_show", 3'd1, 1'b0, 1'b0, 1'b0);
    button = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    expect_out("rst_white", 3'd1, 1'b0, 1'b0, 1'b1);
    step(PRESS_LAT + 3);
    expect_out("held_no_press", 3'd1, 1'b0, 1'b0, 1'b1);
    button = 1'b0;
    step(PRESS_LAT + 1);
    expect_out("held_release", 3'd1, 1'b0, 1'b0, 1'b1);
    press_and_show("after_held", 1'b1, 3'd1, 3'd1);

`ifdef LIGHTS_SEQ_DEBOUNCE_EN
    button = 1'b1;
    step(5);
    button = 1'b0;
    step(DEB + 6);
    expect_out("glitch", 3'd1, 1'b1, 1'b1, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
